plc_input_scan: RTL

PLC_INPUT_SCAN -- requirements
Module: plc_input_scan

---
 rtl/plc_pkg.sv | 22 ++
 rtl/plc_debounce_bit.sv | 81 ++++++++
 rtl/plc_input_scan.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/plc_pkg.sv
// ----------------------------------------------------------------------------
// plc_pkg
// Shared constants for the PLC input path. The rung scanner and the Timer
// users also import this package.
//   PLC_N_IN              number of physical inputs ({KEY, SW} = 4 + 19)
//   PLC_DEB_TICKS_DEFAULT debounce qualification time in 1 ms tick pulses
//   PLC_KEY_INV_MASK      bits inverted after sync (active-low KEY inputs)
//   scan_state_e          scan-tracking FSM encoding, visible on debug port
// ----------------------------------------------------------------------------
package plc_pkg;

   localparam int PLC_N_IN              = 23;
   localparam int PLC_DEB_TICKS_DEFAULT = 8;
   localparam logic [PLC_N_IN-1:0] PLC_KEY_INV_MASK = 23'h78_0000;

   typedef enum logic [1:0] {
      SCAN_IDLE  = 2'd0,   // no scan_start seen since reset
      SCAN_FIRST = 2'd1,   // inside the first scan after reset
      SCAN_RUN   = 2'd2    // every later scan
   } scan_state_e;

endpackage

// File: rtl/plc_debounce_bit.sv
// ----------------------------------------------------------------------------
// plc_debounce_bit
// One-bit debouncer. The output q only follows d after d has differed from
// q for DEB_TICKS tick pulses without interruption; any return of d to q
// restarts the qualification from zero. DEB_TICKS = 0 gives a plain
// one-register delay with no counter.
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous, active-low reset (clears q and the counter)
//   tick  in  one-clk 1 kHz enable pulse
//   d     in  synchronized input bit
//   q     out debounced (stable) bit
// ----------------------------------------------------------------------------
module plc_debounce_bit
   import plc_pkg::*;
#(
   parameter int DEB_TICKS = PLC_DEB_TICKS_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic d,
   output logic q
);

   generate
      if (DEB_TICKS == 0) begin : g_direct
         logic stable_q;
         logic stable_d;
         logic tick_unused;

         assign tick_unused = tick;

         always_comb begin
            stable_d = d;
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) stable_q <= 1'b0;
            else      stable_q <= stable_d;
         end

         assign q = stable_q;
      end else begin : g_count
         localparam int CW = $clog2(DEB_TICKS + 1);

         logic          stable_q;
         logic          stable_d;
         logic [CW-1:0] cnt_q;
         logic [CW-1:0] cnt_d;

         // The full-count check does not wait for a tick: once the last
         // tick has been counted, stable updates on the very next clk.
         always_comb begin
            stable_d = stable_q;
            cnt_d    = cnt_q;
            if (d == stable_q) begin
               cnt_d = '0;
            end else if (cnt_q == CW'(DEB_TICKS)) begin
               stable_d = d;
               cnt_d    = '0;
            end else if (tick) begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               stable_q <= 1'b0;
               cnt_q    <= '0;
            end else begin
               stable_q <= stable_d;
               cnt_q    <= cnt_d;
            end
         end

         assign q = stable_q;
      end
   endgenerate

endmodule

// File: rtl/plc_input_scan.sv
// ----------------------------------------------------------------------------
// plc_input_scan
// Input image stage of the PLC. Physical inputs are synchronized, the
// active-low keys are inverted, every bit is debounced, and on each
// scan_start the debounced vector is frozen into in_img for one whole scan
// together with per-bit rising/falling edge flags.
//
// Build option: define PLC_INPUT_EDGE_EN to build the in_rise/in_fall
// registers. Without it both outputs are tied to 0.
//
// Ports:
//   clk         in  system clock (CLOCK_50 domain)
//   rst         in  asynchronous, active-low reset
//   tick        in  one-clk 1 kHz enable pulse
//   scan_start  in  one-clk pulse when the rung counter wraps to 0
//   raw_in      in  asynchronous physical inputs, {KEY, SW} by default
//   in_img      out debounced input image, held for one scan
//   in_rise     out 0->1 per bit between consecutive images
//   in_fall     out 1->0 per bit between consecutive images
//   img_valid   out one-clk pulse in the cycle after an image latch
//   first_scan  out high for the whole first scan after reset
//   scan_state  out debug view of the scan-tracking FSM
// ----------------------------------------------------------------------------
module plc_input_scan
   import plc_pkg::*;
#(
   parameter int              N_IN      = PLC_N_IN,
   parameter int              DEB_TICKS = PLC_DEB_TICKS_DEFAULT,
   parameter logic [N_IN-1:0] INV_MASK  = N_IN'(PLC_KEY_INV_MASK)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tick,
   input  logic            scan_start,
   input  logic [N_IN-1:0] raw_in,
   output logic [N_IN-1:0] in_img,
   output logic [N_IN-1:0] in_rise,
   output logic [N_IN-1:0] in_fall,
   output logic            img_valid,
   output logic            first_scan,
   output scan_state_e     scan_state
);

   // ---------------------------------------------------------------- sync
   logic [N_IN-1:0] sync1_q, sync1_d;
   logic [N_IN-1:0] sync2_q, sync2_d;
   logic [N_IN-1:0] sync_in;

   always_comb begin
      sync1_d = raw_in;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign sync_in = sync2_q ^ INV_MASK;

   // ------------------------------------------------------------ debounce
   logic [N_IN-1:0] stable;

   generate
      for (genvar i = 0; i < N_IN; i++) begin : g_bit
         plc_debounce_bit #(
            .DEB_TICKS (DEB_TICKS)
         ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .tick (tick),
            .d    (sync_in[i]),
            .q    (stable[i])
         );
      end
   endgenerate

   // --------------------------------------------------------- image latch
   // stable is a register output, so a debounce update on the same edge as
   // scan_start is not seen here until the next scan.
   logic [N_IN-1:0] in_img_q, in_img_d;
   logic            img_valid_q, img_valid_d;

   always_comb begin
      in_img_d    = in_img_q;
      img_valid_d = scan_start;
      if (scan_start) in_img_d = stable;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_img_q    <= '0;
         img_valid_q <= 1'b0;
      end else begin
         in_img_q    <= in_img_d;
         img_valid_q <= img_valid_d;
      end
   end

   assign in_img    = in_img_q;
   assign img_valid = img_valid_q;

   // --------------------------------------------------------------- edges
`ifdef PLC_INPUT_EDGE_EN
   logic [N_IN-1:0] in_rise_q, in_rise_d;
   logic [N_IN-1:0] in_fall_q, in_fall_d;

   always_comb begin
      in_rise_d = in_rise_q;
      in_fall_d = in_fall_q;
      if (scan_start) begin
         in_rise_d =  stable & ~in_img_q;
         in_fall_d = ~stable &  in_img_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_rise_q <= '0;
         in_fall_q <= '0;
      end else begin
         in_rise_q <= in_rise_d;
         in_fall_q <= in_fall_d;
      end
   end

   assign in_rise = in_rise_q;
   assign in_fall = in_fall_q;
`else
   assign in_rise = '0;
   assign in_fall = '0;
`endif

   // ------------------------------------------------ scan-tracking FSM
   scan_state_e state_q, state_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= SCAN_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (scan_start) begin
         case (state_q)
            SCAN_IDLE:  state_d = SCAN_FIRST;
            SCAN_FIRST: state_d = SCAN_RUN;
            SCAN_RUN:   state_d = SCAN_RUN;
            default:    state_d = SCAN_IDLE;
         endcase
      end
   end

   always_comb begin
      first_scan = (state_q == SCAN_FIRST);
      scan_state = state_q;
   end

endmodule
